mbisr_chain_access_ctrl: RTL and testbench

Sequencer for a daisy chain of MBISR repair registers. Each register is a 22-bit-style shift/capture register with a negedge retimed serial output. The controller issues an optional capture cycle, then shifts exactly CHAIN_LEN bits. It unloads the chain's serial output into a word-wide output stream and loads the serial input from a word-wide input stream, gating the chain clock whenever either stream stalls. It sits between the repair/fuse-programming logic and the chain of MBISR register wrappers.

---
 rtl/mbisr_chain_access_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_mbisr_chain_access_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mbisr_chain_access_ctrl.sv
// mbisr_chain_access_ctrl: sequencer for a daisy chain of MBISR repair registers.
// Issues an optional capture cycle, then shifts CHAIN_LEN bits while unloading
// chain_so into a word stream and loading chain_si from a word stream. The chain
// clock enable is dropped whenever either stream stalls.
// Optional feature: define MBISR_CHAIN_ACCESS_CTRL_PARITY_EN to add the
// unload_parity output (XOR of all unloaded bits).
module mbisr_chain_access_ctrl #(
  parameter int unsigned CHAIN_LEN = 22,
  parameter int unsigned WORD_W    = 8,
  parameter int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic              capture,
  output logic              busy,
  output logic              done,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              chain_cken,
  output logic              chain_se,
  output logic              chain_si,
  input  logic              chain_so
`ifdef MBISR_CHAIN_ACCESS_CTRL_PARITY_EN
  ,
  output logic              unload_parity
`endif
);

  localparam int unsigned IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_SHIFT,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WORD_W-1:0] asm_q, asm_d;
  logic              asm_full_q, asm_full_d;
  logic [WORD_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;

  logic              fire;
  logic              last_bit;
  logic              word_end;
  logic              out_free;
  logic [WORD_W-1:0] asm_base;

  // State, counters and both word buffers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      asm_q       <= '0;
      asm_full_q  <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      asm_q       <= asm_d;
      asm_full_q  <= asm_full_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state, buffer movement and chain control
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    asm_d       = asm_q;
    asm_full_d  = asm_full_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    asm_base    = '0;
    busy        = 1'b0;
    done        = 1'b0;
    in_ready    = 1'b0;
    chain_cken  = 1'b0;
    chain_se    = 1'b0;
    chain_si    = 1'b0;

    last_bit = (cnt_q == CNT_LAST);
    word_end = (idx_q == IDX_LAST) || last_bit;
    out_free = !out_valid_q || out_ready;
    // A full assembly word only blocks a new bit if it cannot move out this cycle
    fire     = (state_q == S_SHIFT) && in_valid && (!asm_full_q || out_free);

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (asm_full_q && out_free) begin
      out_data_d  = asm_q;
      out_valid_d = 1'b1;
      asm_full_d  = 1'b0;
      asm_d       = '0;
    end

    // A completed word skips the assembly register when out_data is free, which
    // keeps the final word one cycle after the final shift.
    if (fire) begin
      asm_base        = asm_full_q ? '0 : asm_q;
      asm_base[idx_q] = chain_so;
      if (word_end) begin
        if (!asm_full_q && out_free) begin
          out_data_d  = asm_base;
          out_valid_d = 1'b1;
          asm_d       = '0;
        end else begin
          asm_d      = asm_base;
          asm_full_d = 1'b1;
        end
        idx_d = '0;
      end else begin
        asm_d = asm_base;
        idx_d = idx_q + 1'b1;
      end
      cnt_d = cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        cnt_d      = '0;
        idx_d      = '0;
        asm_d      = '0;
        asm_full_d = 1'b0;
        if (start) begin
          state_d = capture ? S_CAPTURE : S_SHIFT;
        end
      end
      S_CAPTURE: begin
        busy       = 1'b1;
        chain_cken = 1'b1;
        state_d    = S_SHIFT;
      end
      S_SHIFT: begin
        busy       = 1'b1;
        chain_se   = 1'b1;
        chain_cken = fire;
        chain_si   = fire ? in_data[idx_q] : 1'b0;
        in_ready   = fire && word_end;
        if (fire && last_bit) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (!out_valid_q && !asm_full_q) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

`ifdef MBISR_CHAIN_ACCESS_CTRL_PARITY_EN
  logic parity_q, parity_d;

  // Running XOR of unloaded bits, cleared when an operation is launched
  always_comb begin
    parity_d = parity_q;
    if (state_q == S_IDLE && start) begin
      parity_d = 1'b0;
    end else if (fire) begin
      parity_d = parity_q ^ chain_so;
    end
  end

  // Parity register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end

  assign unload_parity = parity_q;
`endif

endmodule

// File: tb/tb_mbisr_chain_access_ctrl.sv
// Scoreboard bench for mbisr_chain_access_ctrl with a behavioural chain model.
module tb_mbisr_chain_access_ctrl;

  localparam int CL = 22;
  localparam int WW = 8;
  localparam int NW = (CL + WW - 1) / WW;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          start = 1'b0;
  logic          capture = 1'b0;
  logic          busy, done;
  logic [WW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [WW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          chain_cken, chain_se, chain_si, chain_so;
`ifdef MBISR_CHAIN_ACCESS_CTRL_PARITY_EN
  logic          unload_parity;
`endif

  mbisr_chain_access_ctrl #(
    .CHAIN_LEN(CL),
    .WORD_W   (WW)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .start     (start),
    .capture   (capture),
    .busy      (busy),
    .done      (done),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .chain_cken(chain_cken),
    .chain_se  (chain_se),
    .chain_si  (chain_si),
    .chain_so  (chain_so)
`ifdef MBISR_CHAIN_ACCESS_CTRL_PARITY_EN
    ,
    .unload_parity(unload_parity)
`endif
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Chain model: shift toward bit 0, serial out retimed on negedge
  logic [CL-1:0] chain_q = '0;
  logic [CL-1:0] cap_d = '0;
  logic ck_s = 1'b0, se_s = 1'b0, si_s = 1'b0, so_r = 1'b0;
  int   shift_cnt = 0;
  assign chain_so = so_r;

  always @(negedge CLK) begin
    ck_s = chain_cken;
    se_s = chain_se;
    si_s = chain_si;
    so_r = chain_q[0];
  end

  always @(posedge CLK) begin
    if (ck_s) begin
      if (se_s) begin
        chain_q = {si_s, chain_q[CL-1:1]};
        shift_cnt++;
      end else begin
        chain_q = cap_d;
      end
    end
  end

  // Stream drivers
  logic [WW-1:0] in_words[$];
  logic [WW-1:0] exp_q[$];
  int  in_mode = 0, out_mode = 0;
  int  starve_at = 0, starve_left = 0, bp_left = 0;
  bit  starve_armed = 0, bp_armed = 0;
  bit  ihs;

  always begin
    @(negedge CLK);
    ihs = in_valid && in_ready;
    @(posedge CLK);
    #1;
    if (ihs && in_words.size() > 0) void'(in_words.pop_front());
    if (in_mode == 2 && starve_armed && shift_cnt >= starve_at) begin
      starve_armed = 0;
      starve_left  = 5;
    end
    if (starve_left > 0) begin
      in_valid = 1'b0;
      starve_left--;
    end else begin
      in_valid = (in_words.size() > 0) && (in_mode != 1 || $urandom_range(3) != 0);
    end
    in_data = (in_words.size() > 0) ? in_words[0] : WW'($urandom);
    if (bp_armed && out_valid) begin
      bp_armed = 0;
      bp_left  = 10;
    end
    if (bp_left > 0) begin
      out_ready = 1'b0;
      bp_left--;
    end else begin
      out_ready = (out_mode != 1) || ($urandom_range(1) == 1);
    end
  end

  // Monitor: pops expected words on each accepted unload word
  int done_cnt = 0;
  logic [WW-1:0] wexp;

  always @(negedge CLK) begin
    if (done) done_cnt++;
    if (chain_se && !in_valid) chk("stall_cken", 64'(chain_cken), 64'd0);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %0h expected no word", out_data);
      end else begin
        wexp = exp_q.pop_front();
        chk("out_word", 64'(out_data), 64'(wexp));
      end
    end
  end

  // Reference: unload bits are the prior contents, new contents are the loaded bits
  logic [CL-1:0] ref_chain = '0;
  bit            ref_valid = 0;

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_out_data"}, 64'(out_data), 64'd0);
    chk({tag, "_cken"}, 64'(chain_cken), 64'd0);
    chk({tag, "_se"}, 64'(chain_se), 64'd0);
    chk({tag, "_si"}, 64'(chain_si), 64'd0);
`ifdef MBISR_CHAIN_ACCESS_CTRL_PARITY_EN
    chk({tag, "_parity"}, 64'(unload_parity), 64'd0);
`endif
  endtask

  task automatic recover();
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #2;
    RST = 1'b0;
    exp_q.delete();
    in_words.delete();
    ref_valid = 0;
  endtask

  task automatic run_op(input bit cap, input logic [CL-1:0] d, input logic [NW*WW-1:0] words,
                        input int imode, input int omode, input bit lat, input bit midstart);
    logic [NW*WW-1:0] src;
    int sc0, dc0, cyc;
    bit got;
    src = '0;
    src[CL-1:0] = cap ? d : ref_chain;
    cap_d    = d;
    in_mode  = imode;
    out_mode = omode;
    bp_armed = (omode == 2);
    for (int k = 0; k < NW; k++) begin
      exp_q.push_back(src[k*WW +: WW]);
      in_words.push_back(words[k*WW +: WW]);
    end
    sc0 = shift_cnt;
    dc0 = done_cnt;
    if (imode == 2) begin
      starve_at    = sc0 + 3;
      starve_armed = 1;
    end
    @(posedge CLK);
    #1;
    start   = 1'b1;
    capture = cap;
    @(posedge CLK);
    #1;
    start   = 1'b0;
    capture = 1'($urandom_range(1));
    cyc = 0;
    got = 0;
    while (!got && cyc < 2000) begin
      @(negedge CLK);
      cyc++;
      if (done) begin
        got = 1;
        chk("busy_at_done", 64'(busy), 64'd0);
      end
      if (midstart && cyc == 8) begin
        start   = 1'b1;
        capture = 1'b1;
      end
      if (midstart && cyc == 9) start = 1'b0;
    end
    start = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done after %0d cycles, required a done pulse", cyc);
      recover();
      return;
    end
    if (lat) chk("done_latency", 64'(cyc), 64'(CL + (cap ? 4 : 3)));
    @(negedge CLK);
    chk("words_left", 64'(exp_q.size()), 64'd0);
    chk("chain_contents", 64'(chain_q), 64'(words[CL-1:0]));
    chk("shift_edges", 64'(shift_cnt - sc0), 64'(CL));
`ifdef MBISR_CHAIN_ACCESS_CTRL_PARITY_EN
    chk("unload_parity", 64'(unload_parity), 64'(^src[CL-1:0]));
`endif
    if (midstart) repeat (30) @(negedge CLK);
    chk("done_count", 64'(done_cnt - dc0), 64'd1);
    ref_chain = words[CL-1:0];
    ref_valid = 1;
    in_mode   = 0;
    out_mode  = 0;
  endtask

  task automatic run_abort();
    int sc0, dc0, n;
    logic [CL-1:0] d;
    d = CL'($urandom);
    cap_d = d;
    for (int k = 0; k < NW; k++) begin
      exp_q.push_back(WW'({2'b00, d} >> (k * WW)));
      in_words.push_back(WW'($urandom));
    end
    sc0 = shift_cnt;
    dc0 = done_cnt;
    @(posedge CLK);
    #1;
    start   = 1'b1;
    capture = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
    n = 0;
    while (shift_cnt - sc0 < 10 && n < 200) begin
      @(posedge CLK);
      n++;
    end
    if (shift_cnt - sc0 < 10) begin
      checks++;
      errors++;
      $display("FAIL abort_wait: got %0d shifts, required 10", shift_cnt - sc0);
    end
    #2;
    RST = 1'b1;
    @(posedge CLK);
    #1;
    check_outputs_zero("abort");
    @(negedge CLK);
    RST = 1'b0;
    exp_q.delete();
    in_words.delete();
    ref_valid = 0;
    repeat (40) @(negedge CLK);
    chk("abort_no_done", 64'(done_cnt - dc0), 64'd0);
  endtask

  logic [CL-1:0]    rd;
  logic [NW*WW-1:0] rw;
  bit               rc;

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    check_outputs_zero("reset");
    @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(posedge CLK);

    // Capture / unload: F1, C0, 03
    run_op(1'b1, 22'h03C0F1, 24'h000000, 0, 0, 1'b1, 1'b0);
    // Load AA, 55, 3F with no capture
    run_op(1'b0, 22'h000000, 24'h3F55AA, 0, 0, 1'b1, 1'b0);
    // Unload backpressure
    run_op(1'b1, 22'h03C0F1, 24'h3F55AA, 0, 2, 1'b0, 1'b0);
    // Input starvation mid-word
    run_op(1'b0, 22'h000000, 24'h3F55AA, 2, 0, 1'b0, 1'b0);
    // Reset mid-shift, then a fresh operation
    run_abort();
    run_op(1'b1, CL'($urandom), NW*WW'($urandom), 0, 0, 1'b1, 1'b0);
    // Start pulsed while busy
    run_op(1'b0, CL'($urandom), NW*WW'($urandom), 0, 0, 1'b0, 1'b1);
    // Randomized traffic on both streams
    for (int i = 0; i < 10; i++) begin
      rd = CL'($urandom);
      rw = NW*WW'($urandom);
      rc = ref_valid ? 1'($urandom_range(1)) : 1'b1;
      run_op(rc, rd, rw, 1, 1, 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
